// File: rtl/frame_read_streamer_if.sv
// Memory-read and pixel-stream bus of the frame read streamer.
// The streamer drives it through the master modport. Memory and consumer use the slave modport.
interface frame_read_streamer_if #(
    parameter int COLS   = 320,
    parameter int ROWS   = 240,
    parameter int DATA_W = 32
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int BW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic              mem_rd_en;
    logic [CW-1:0]     mem_col;
    logic [BW-1:0]     mem_bank;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              sof;
    logic              eol;
    logic              eof;

    modport master (
        output mem_rd_en, mem_col, mem_bank, pix_data, pix_valid, sof, eol, eof,
        input  mem_rd_data, pix_ready
    );

    modport slave (
        input  mem_rd_en, mem_col, mem_bank, pix_data, pix_valid, sof, eol, eof,
        output mem_rd_data, pix_ready
    );
endinterface

// File: rtl/frame_read_streamer.sv
// Streams one frame from banked frame memory in raster order.
// A two-entry buffer is guarded by read credits, so it never overflows.
module frame_read_streamer #(
    parameter int COLS   = 320,
    parameter int ROWS   = 240,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    frame_read_streamer_if.master bus
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int BW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int EW = DATA_W + 3;
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [BW-1:0] BANK_LAST = BW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   col, last_col;
    logic [BW-1:0]   bank, last_bank;
    logic            vld_p1, sof_p1, eol_p1, eof_p1;
    logic [EW-1:0]   buf0, buf1, ent_in;
    logic [1:0]      count, credit;
    logic            issue, pop, push, at_last;

    always_comb begin
        pop     = (count != 2'd0) && bus.pix_ready;
        push    = vld_p1;
        credit  = count + {1'b0, vld_p1};
        at_last = (col == COL_LAST) && (bank == BANK_LAST);
        issue   = (state == READ) && ((credit - {1'b0, pop}) < 2'd2);
        ent_in  = {bus.mem_rd_data, sof_p1, eol_p1, eof_p1};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (issue && at_last) state_nxt = DRAIN;
            DRAIN:   if (pop && buf0[0]) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Address stage: the counters hold the next read address, and last_* hold the address most recently issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            bank      <= '0;
            last_col  <= '0;
            last_bank <= '0;
        end else if (state == IDLE && start) begin
            col  <= '0;
            bank <= '0;
        end else if (issue) begin
            last_col  <= col;
            last_bank <= bank;
            if (col == COL_LAST) begin
                col  <= '0;
                bank <= (bank == BANK_LAST) ? '0 : bank + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Return stage: the read is in flight and its flags wait for the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            sof_p1 <= 1'b0;
            eol_p1 <= 1'b0;
            eof_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue;
            sof_p1 <= issue && (col == '0) && (bank == '0);
            eol_p1 <= issue && (col == COL_LAST);
            eof_p1 <= issue && at_last;
        end
    end

    // Buffer stage: buf0 is the head. Credits guarantee no push arrives while two entries are held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf0  <= '0;
            buf1  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) buf0 <= ent_in;
                    else               buf1 <= ent_in;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    buf0  <= buf1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        buf0 <= ent_in;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= ent_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mem_rd_en = issue;
        bus.mem_col   = issue ? col  : last_col;
        bus.mem_bank  = issue ? bank : last_bank;
        bus.pix_valid = (count != 2'd0);
        bus.pix_data  = buf0[EW-1:3];
        bus.sof       = bus.pix_valid && buf0[2];
        bus.eol       = bus.pix_valid && buf0[1];
        bus.eof       = bus.pix_valid && buf0[0];
        busy          = (state == READ) || (state == DRAIN);
        done          = (state == DONE);
    end
endmodule

// File: tb/tb_frame_read_streamer.sv
// Directed bench for frame_read_streamer: a 4x2 frame instance plus a default-size instance.
// Each memory word is {bank, col}.
module tb_frame_read_streamer;
    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int DW   = 32;
    localparam int NPIX = COLS * ROWS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic busy, done, busy2, done2;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    frame_read_streamer_if #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DW)) bus ();
    frame_read_streamer_if #(.COLS(320), .ROWS(240), .DATA_W(DW)) bus2 ();

    frame_read_streamer #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus.master));

    frame_read_streamer #(.COLS(320), .ROWS(240), .DATA_W(DW)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .bus(bus2.master));

    always @(posedge clk) begin
        if (bus.mem_rd_en)  bus.mem_rd_data  <= DW'({bus.mem_bank, bus.mem_col});
        if (bus2.mem_rd_en) bus2.mem_rd_data <= DW'({bus2.mem_bank, bus2.mem_col});
    end

    typedef struct packed {
        logic          ready;
        logic          valid;
        logic [DW-1:0] data;
        logic          sof, eol, eof, rd_en;
        logic [1:0]    col;
        logic          bank;
        logic          busy, done;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input int r, v, d, s, el, ef, re, c, b, bz, dn);
        vec_t t;
        t.ready = r[0];  t.valid = v[0];  t.data = DW'(d);
        t.sof = s[0];    t.eol = el[0];   t.eof = ef[0];  t.rd_en = re[0];
        t.col = c[1:0];  t.bank = b[0];   t.busy = bz[0]; t.done = dn[0];
        return t;
    endfunction

    function automatic logic [DW-1:0] exp_word(input int i);
        return DW'(((i / COLS) << $clog2(COLS)) | (i % COLS));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1; stall_len: ready low for the first cycles.
    task automatic stream_frame(input string tag, input int mode, input int stall_len, input int restart_at);
        int pix = 0, reads = 0, dones = 0, post = 0, buf_m = 0, infl_m = 0;
        logic held = 1'b0;
        logic p;
        logic [DW+2:0] hv = '0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_at);
            if (cyc < stall_len)  bus.pix_ready = 1'b0;
            else if (mode == 1)   bus.pix_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            else                  bus.pix_ready = 1'b1;
            #1;
            if (stall_len > 0 && cyc == stall_len) begin
                chk({tag, " stall reads"}, 64'(reads), 64'd2);
                chk({tag, " stall valid"}, 64'(bus.pix_valid), 64'd1);
                chk({tag, " stall data"}, 64'(bus.pix_data), 64'(exp_word(0)));
                chk({tag, " stall sof"}, 64'(bus.sof), 64'd1);
            end
            p = bus.pix_valid && bus.pix_ready;
            chk({tag, " valid"}, 64'(bus.pix_valid), 64'(buf_m > 0));
            if (bus.mem_rd_en) begin
                chk({tag, " credit"}, 64'((buf_m + infl_m - int'(p)) < 2), 64'd1);
                chk({tag, " rd col"}, 64'(bus.mem_col), 64'(reads % COLS));
                chk({tag, " rd bank"}, 64'(bus.mem_bank), 64'(reads / COLS));
                reads++;
            end
            if (held)
                chk({tag, " stable"}, 64'({bus.pix_data, bus.sof, bus.eol, bus.eof}), 64'(hv));
            if (p) begin
                chk({tag, " data"}, 64'(bus.pix_data), 64'(exp_word(pix)));
                chk({tag, " flags"}, 64'({bus.sof, bus.eol, bus.eof}),
                    64'({pix == 0, (pix % COLS) == COLS - 1, pix == NPIX - 1}));
                pix++;
            end
            held = bus.pix_valid && !bus.pix_ready;
            hv   = {bus.pix_data, bus.sof, bus.eol, bus.eof};
            if (done) dones++;
            buf_m  = buf_m + infl_m - int'(p);
            infl_m = int'(bus.mem_rd_en);
            if (dones > 0) post++;
            if (post >= 3) break;
        end
        start = 1'b0;
        chk({tag, " pixels"}, 64'(pix), 64'(NPIX));
        chk({tag, " reads"}, 64'(reads), 64'(NPIX));
        chk({tag, " dones"}, 64'(dones), 64'd1);
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        vecs[2]  = mk(1, 1, 0, 1, 0, 0, 1, 2, 0, 1, 0);
        vecs[3]  = mk(1, 1, 1, 0, 0, 0, 1, 3, 0, 1, 0);
        vecs[4]  = mk(1, 1, 2, 0, 0, 0, 1, 0, 1, 1, 0);
        vecs[5]  = mk(1, 1, 3, 0, 1, 0, 1, 1, 1, 1, 0);
        vecs[6]  = mk(1, 1, 4, 0, 0, 0, 1, 2, 1, 1, 0);
        vecs[7]  = mk(1, 1, 5, 0, 0, 0, 1, 3, 1, 1, 0);
        vecs[8]  = mk(1, 1, 6, 0, 0, 0, 0, 3, 1, 1, 0);
        vecs[9]  = mk(1, 1, 7, 0, 1, 1, 0, 3, 1, 1, 0);
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 1);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0);

        bus.pix_ready  = 1'b1;
        bus2.pix_ready = 1'b1;
        #2;
        chk("reset outputs", 64'({bus.mem_rd_en, bus.pix_valid, bus.sof, bus.eol, bus.eof, busy, done}), 64'd0);
        chk("reset data", 64'(bus.pix_data), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic frame, checked cycle by cycle against the table.
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            bus.pix_ready = vecs[i].ready;
            #1;
            chk($sformatf("vec%0d ctl", i),
                64'({bus.pix_valid, bus.sof, bus.eol, bus.eof, bus.mem_rd_en, bus.mem_col, bus.mem_bank, busy, done}),
                64'({vecs[i].valid, vecs[i].sof, vecs[i].eol, vecs[i].eof, vecs[i].rd_en,
                     vecs[i].col, vecs[i].bank, vecs[i].busy, vecs[i].done}));
            if (vecs[i].valid)
                chk($sformatf("vec%0d data", i), 64'(bus.pix_data), 64'(vecs[i].data));
        end

        stream_frame("toggle", 1, 0, -1);
        stream_frame("stall20", 0, 20, -1);
        stream_frame("restart", 0, 0, 3);

        // Reset while the read for col 2, bank 1 is being issued.
        begin
            bit found = 1'b0;
            @(negedge clk);
            start = 1'b1;
            bus.pix_ready = 1'b1;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                start = 1'b0;
                #1;
                if (bus.mem_rd_en && bus.mem_col == 2'd2 && bus.mem_bank == 1'b1) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("reset point reached", 64'(found), 64'd1);
            rst = 1'b1;
            #1;
            chk("midreset outputs", 64'({bus.mem_rd_en, bus.pix_valid, bus.sof, bus.eol, bus.eof, busy, done}), 64'd0);
            chk("midreset data", 64'(bus.pix_data), 64'd0);
            chk("midreset addr", 64'({bus.mem_col, bus.mem_bank}), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                #1;
                chk($sformatf("postreset quiet%0d", c), 64'({bus.mem_rd_en, bus.pix_valid, busy}), 64'd0);
            end
        end
        stream_frame("after reset", 0, 0, -1);

        // Default-size frame.
        begin
            int pix = 0, eols = 0, eofs = 0;
            bit got_done = 1'b0;
            logic [DW-1:0] last_data = '0;
            @(negedge clk);
            start2 = 1'b1;
            for (int c = 0; c < 80000; c++) begin
                @(negedge clk);
                start2 = 1'b0;
                #1;
                if (bus2.pix_valid && bus2.pix_ready) begin
                    pix++;
                    if (bus2.eol) eols++;
                    if (bus2.eof) begin
                        eofs++;
                        last_data = bus2.pix_data;
                    end
                end
                if (done2) begin
                    got_done = 1'b1;
                    break;
                end
            end
            chk("big done", 64'(got_done), 64'd1);
            chk("big pixels", 64'(pix), 64'd76800);
            chk("big eols", 64'(eols), 64'd240);
            chk("big eofs", 64'(eofs), 64'd1);
            chk("big last data", 64'(last_data), 64'({8'd239, 9'd319}));
            chk("big last col", 64'(bus2.mem_col), 64'd319);
            chk("big last bank", 64'(bus2.mem_bank), 64'd239);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_read_streamer.md
FRAME_READ_STREAMER -- requirements
Module: frame_read_streamer

Interface
REQ-001 Parameter COLS, default 320: pixels per line, equal to the frame-memory word depth per bank.
REQ-002 Parameter ROWS, default 240: lines per frame, equal to the frame-memory bank count.
REQ-003 Parameter DATA_W, default 32: pixel word width.
REQ-004 The block SHALL run on one clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1: rising-edge clock for all state.
REQ-006 Port rst, input, 1: asynchronous active-high reset.
REQ-007 Port start, input, 1: single-cycle request to stream one full frame.
REQ-008 Port mem_rd_en, output, 1: read strobe to the frame memory.
REQ-009 Port mem_col, output, clog2(COLS): word address within a bank.
REQ-010 Port mem_bank, output, clog2(ROWS): bank (line) select.
REQ-011 Port mem_rd_data, input, DATA_W: memory read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 Port pix_data, output, DATA_W: streamed pixel.
REQ-013 Port pix_valid, output, 1: pix_data and the flags are valid.
REQ-014 Port pix_ready, input, 1: consumer accepts a pixel when pix_valid && pix_ready.
REQ-015 Port sof / eol / eof, output, 1 each: first pixel of frame / last pixel of line / last pixel of frame, qualified by pix_valid.
REQ-016 Port busy, output, 1: high from the cycle after an accepted start until done.
REQ-017 Port done, output, 1: one-cycle pulse after the last pixel is accepted.

Function
REQ-018 FSM states: IDLE, READ (issuing reads), DRAIN (all reads issued, buffer not empty), DONE (one cycle).
REQ-019 IDLE->READ on start; counters clear to col=0, bank=0 on the same edge.
REQ-020 start SHALL be ignored in READ, DRAIN and DONE.
REQ-021 Reads SHALL issue in raster order: col increments 0..COLS-1, then wraps to 0 with bank+1.
REQ-022 Data buffer: 2 entries; credit = buffered entries + in-flight read (0..2).
REQ-023 A read SHALL issue in READ only when (credit - pop_this_cycle) < 2; the buffer never overflows, and with pix_ready held high one pixel is output per cycle.
REQ-024 Returning mem_rd_data SHALL be captured unconditionally on the cycle after mem_rd_en.
REQ-025 sof, eol and eof SHALL travel with their pixel through the buffer; a pixel at col COLS-1 asserts eol, and a pixel at col COLS-1, bank ROWS-1 asserts eol and eof.
REQ-026 pix_data and the flags SHALL hold stable while pix_valid && !pix_ready.
REQ-027 READ->DRAIN on the edge that issues the read for (COLS-1, ROWS-1).
REQ-028 DRAIN->DONE on the edge that accepts the eof pixel; DONE->IDLE on the next edge; done is high only in DONE.
REQ-029 mem_col and mem_bank SHALL be driven only when mem_rd_en is high; otherwise they hold their last values.
REQ-030 Total pixels per frame SHALL equal exactly COLS*ROWS.

Reset
REQ-031 On rst, regardless of clk: state=IDLE; counters=0; buffer and in-flight flag cleared; mem_rd_en, pix_valid, sof, eol, eof, busy and done = 0; pix_data = 0.
REQ-032 A reset mid-frame SHALL abort the frame with no further reads, and a return read arriving after reset release SHALL be discarded.

Verification
REQ-033 Scenario: COLS=4, ROWS=2, pix_ready=1, memory word = {bank,col}, start -> 8 pixels in raster order on consecutive cycles; sof on pixel 0; eol on pixels 3 and 7; eof on pixel 7; done one cycle after pixel 7.
REQ-034 Scenario: pix_ready toggles 1,0,0,1 repeatedly -> no pixel lost or duplicated, data stable while stalled, and mem_rd_en never issued with credit already 2.
REQ-035 Scenario: pix_ready=0 for 20 cycles after start -> exactly 2 reads issued, pix_valid=1 holding pixel (0,0).
REQ-036 Scenario: start pulsed again during READ -> ignored; exactly COLS*ROWS pixels and one done.
REQ-037 Scenario: rst asserted mid-line at col=2, bank=1 -> all outputs 0 immediately; a later start streams a full frame from (0,0).
REQ-038 Scenario: default parameters -> 76800 pixels, 240 eol, 1 eof, and the final address is col=319, bank=239.
